// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_DEFAULT_STABLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic asyncResetN,
  input  logic d,
  output logic q
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw button into a registered level plus one-cycle press pulse.
// Optional one-cycle release pulse on btnFall when DEBOUNCE_FALL_PULSE_EN is defined.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_STABLE,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       asyncResetN,
  input  logic       btnIn,
  output logic       btnLevel,
  output logic       btnRise,
  output logic       busy,
  output logic [1:0] dbgState
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic       btnFall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s_sync;
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic             fall_q, fall_d;
`endif

  sync_2ff u_sync (
    .clk         (clk),
    .asyncResetN (asyncResetN),
    .d           (btnIn),
    .q           (s_sync)
  );

  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q  <= fall_d;
`endif
    end
  end

  // Pulses default low so they can only be high for the accepting cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
    fall_d  = 1'b0;
`endif
    case (state_q)
      LOW: begin
        if (s_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s_sync) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s_sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          level_d = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
          fall_d  = 1'b1;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btnLevel = level_q;
  assign btnRise  = rise_q;
  assign busy     = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
  assign dbgState = state_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
  assign btnFall  = fall_q;
`endif

endmodule
